// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the PC, issues word fetches on a req/gnt/rvalid bus,
// buffers returned words with their PCs and delivers them in order to IF/ID.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    // Bus handshake: a request transfers when ibus_req_o && ibus_gnt_i on a rising edge;
    // until granted, req and addr stay stable (only a flush may withdraw them). Each grant
    // gets exactly one ibus_rvalid_i later, in grant order.

    logic              rst_q;
    logic [31:0]       pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     q_count;
    logic [AW-1:0]     q_rd, q_wr;
    logic [AW-1:0]     a_rd, a_wr;
    logic [31:0]       q_inst [FIFO_DEPTH];
    logic [31:0]       q_pc   [FIFO_DEPTH];
    logic [31:0]       a_pc   [FIFO_DEPTH];

    logic              flush, pop, fire, push, drop_rsp;
    logic [CW:0]       used;
    logic              unused_bits;

    assign flush    = branch_flag_i;
    assign pop      = inst_valid_o && !stall_i[0];
    assign fire     = ibus_req_o && ibus_gnt_i;
    assign drop_rsp = ibus_rvalid_i && (drop_cnt != '0);
    assign push     = ibus_rvalid_i && (drop_cnt == '0);

    // Queue slots already spoken for: buffered words plus in-flight requests.
    assign used        = {1'b0, q_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop};
    assign ibus_req_o  = !rst_q && !flush && (used < DEPTH_W);
    assign ibus_addr_o = pc;

    assign inst_valid_o = (q_count != '0);
    assign inst_o       = inst_valid_o ? q_inst[q_rd] : NOP;
    assign inst_addr_o  = inst_valid_o ? q_pc[q_rd]   : 32'h0;

    assign unused_bits = ^{stall_i[2:1], branch_addr_i[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q       <= 1'b1;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            q_count     <= '0;
            q_rd        <= '0;
            q_wr        <= '0;
            a_rd        <= '0;
            a_wr        <= '0;
        end else begin
            rst_q       <= 1'b0;
            outstanding <= outstanding + CW'(fire) - CW'(ibus_rvalid_i);
            if (flush) begin
                // Everything still in flight after this edge is stale and must be dropped.
                pc       <= {branch_addr_i[31:2], 2'b00};
                drop_cnt <= outstanding + CW'(fire) - CW'(ibus_rvalid_i);
                q_count  <= '0;
                q_rd     <= '0;
                q_wr     <= '0;
                a_rd     <= '0;
                a_wr     <= '0;
            end else begin
                if (fire) begin
                    pc   <= pc + 32'd4;
                    a_wr <= a_wr + AW'(1);
                end
                if (drop_rsp) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    a_rd <= a_rd + AW'(1);
                    q_wr <= q_wr + AW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + AW'(1);
                end
                q_count <= q_count + CW'(push) - CW'(pop);
            end
        end
    end

    // Payload storage carries no reset; validity comes from the pointers and counts.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (fire) begin
                a_pc[a_wr] <= pc;
            end
            if (push) begin
                q_inst[q_wr] <= ibus_rdata_i;
                q_pc[q_wr]   <= a_pc[a_rd];
            end
        end
    end

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (rst) !(ibus_rvalid_i && (outstanding == '0)));

    req_held_until_gnt: assert property (
        @(posedge clk) disable iff (rst)
        (ibus_req_o && !ibus_gnt_i) |=> ($stable(ibus_addr_o) && (ibus_req_o || branch_flag_i)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: cycle table for streaming/stall/gnt-withhold, then
// hand-written redirect, redirect-under-stall, PC wrap and mid-burst reset sequences.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [2:0]  stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifu_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bench state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          lat    = 1;
    logic        rst_b, stall_b, br, gnt_en;
    logic [31:0] br_addr;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_inst, s_iaddr;

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_iaddr;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    function automatic vec_t mk(input logic st, input logic g, input logic rq,
                                input logic [31:0] ad, input logic v, input logic [31:0] ia);
        vec_t r;
        r.stall = st; r.gnt = g; r.exp_req = rq; r.exp_addr = ad; r.exp_valid = v; r.exp_iaddr = ia;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- driver + memory model + scoreboard, one cycle per call ----------------
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        rst           = rst_b;
        stall_i       = {2'($urandom_range(0, 3)), stall_b};
        branch_flag_i = br;
        branch_addr_i = br ? br_addr : $urandom();
        if (rst_b) begin
            pend_addr.delete();
            pend_due.delete();
        end
        ibus_gnt_i    = gnt_en && !rst_b;
        ibus_rvalid_i = !rst_b && (pend_addr.size() != 0) && (pend_due[0] <= cyc);
        ibus_rdata_i  = ibus_rvalid_i ? mem_word(pend_addr[0]) : 32'h0;
        #1;
        s_req   = ibus_req_o;
        s_addr  = ibus_addr_o;
        s_valid = inst_valid_o;
        s_inst  = inst_o;
        s_iaddr = inst_addr_o;
        if (ibus_rvalid_i) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (s_req && ibus_gnt_i) begin
            pend_addr.push_back(s_addr);
            pend_due.push_back(cyc + lat);
        end
        if (!rst_b && !br && s_valid && !stall_b) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_delivery (cycle %0d): got addr %h, expected none", cyc, s_iaddr);
            end else begin
                e = exp_q.pop_front();
                check("deliver_addr", s_iaddr, e);
                check("deliver_inst", s_inst, mem_word(e));
            end
        end
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, s_req},   32'h0);
        check({tag, "_addr"},  s_addr,           32'h0);
        check({tag, "_valid"}, {31'b0, s_valid}, 32'h0);
        check({tag, "_inst"},  s_inst,           NOP);
        check({tag, "_iaddr"}, s_iaddr,          32'h0);
    endtask

    task automatic do_reset();
        rst_b = 1'b1; stall_b = 1'b0; br = 1'b0; br_addr = 32'h0; gnt_en = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        exp_q.delete();
        rst_b = 1'b0;
    endtask

    task automatic drain(input int max, input string name);
        for (int i = 0; i < max && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d deliveries still missing, expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; stall_i = 3'b0; branch_flag_i = 1'b0; branch_addr_i = 32'h0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;

        //            stall gnt req addr          valid iaddr
        tbl[0]  = mk(0, 1, 0, 32'h00, 0, 32'h00);  // rst_q still high
        tbl[1]  = mk(0, 1, 1, 32'h00, 0, 32'h00);
        tbl[2]  = mk(0, 1, 1, 32'h04, 0, 32'h00);
        tbl[3]  = mk(0, 1, 1, 32'h08, 1, 32'h00);  // 2 cycles after first gnt
        tbl[4]  = mk(0, 1, 1, 32'h0C, 1, 32'h04);
        tbl[5]  = mk(1, 1, 0, 32'h10, 1, 32'h08);  // stall: credits exhausted
        tbl[6]  = mk(1, 1, 0, 32'h10, 1, 32'h08);
        tbl[7]  = mk(1, 1, 0, 32'h10, 1, 32'h08);
        tbl[8]  = mk(1, 1, 0, 32'h10, 1, 32'h08);
        tbl[9]  = mk(1, 1, 0, 32'h10, 1, 32'h08);
        tbl[10] = mk(0, 1, 1, 32'h10, 1, 32'h08);
        tbl[11] = mk(0, 1, 1, 32'h14, 1, 32'h0C);
        tbl[12] = mk(0, 1, 1, 32'h18, 1, 32'h10);
        tbl[13] = mk(0, 0, 1, 32'h1C, 1, 32'h14);  // gnt withheld 4 cycles
        tbl[14] = mk(0, 0, 1, 32'h1C, 1, 32'h18);
        tbl[15] = mk(0, 0, 1, 32'h1C, 0, 32'h00);
        tbl[16] = mk(0, 0, 1, 32'h1C, 0, 32'h00);
        tbl[17] = mk(0, 1, 1, 32'h1C, 0, 32'h00);
        tbl[18] = mk(0, 1, 1, 32'h20, 0, 32'h00);
        tbl[19] = mk(0, 1, 1, 32'h24, 1, 32'h1C);

        // Streaming, stall and withheld grant
        lat = 1;
        do_reset();
        for (int a = 0; a <= 32'h1C; a += 4) exp_q.push_back(32'(a));
        for (int i = 0; i < 20; i++) begin
            stall_b = tbl[i].stall;
            gnt_en  = tbl[i].gnt;
            step();
            check("tbl_req",   {31'b0, s_req},   {31'b0, tbl[i].exp_req});
            check("tbl_addr",  s_addr,           tbl[i].exp_addr);
            check("tbl_valid", {31'b0, s_valid}, {31'b0, tbl[i].exp_valid});
            check("tbl_iaddr", s_iaddr,          tbl[i].exp_iaddr);
            check("tbl_inst",  s_inst,           tbl[i].exp_valid ? mem_word(tbl[i].exp_iaddr) : NOP);
        end
        drain(0, "table_drain");

        // Redirect with two stale requests in flight
        lat = 3;
        do_reset();
        step(); step(); step();
        br = 1'b1; br_addr = 32'h0000_0103;
        step();
        check("br_req_forced_low", {31'b0, s_req}, 32'h0);
        br = 1'b0;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        step();
        check("br_target_addr", s_addr, 32'h100);
        check("br_valid_cleared", {31'b0, s_valid}, 32'h0);
        check("br_req_credit", {31'b0, s_req}, 32'h0);
        step();
        check("br_first_req", {31'b0, s_req}, 32'h1);
        check("br_first_addr", s_addr, 32'h100);
        drain(20, "br_drain");

        // Second redirect while stale responses are still being dropped
        lat = 3;
        do_reset();
        step(); step(); step();
        br = 1'b1; br_addr = 32'h0000_0103;
        step();
        br = 1'b1; br_addr = 32'h0000_0200;
        step();
        check("br2_mid_addr", s_addr, 32'h100);
        br = 1'b0;
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        step();
        check("br2_target_addr", s_addr, 32'h200);
        drain(20, "br2_drain");

        // Redirect and stall in the same cycle with a full queue
        lat = 1;
        do_reset();
        step(); step(); step();
        stall_b = 1'b1;
        step();
        check("stbr_hold_iaddr", s_iaddr, 32'h0);
        check("stbr_req_low", {31'b0, s_req}, 32'h0);
        br = 1'b1; br_addr = 32'h0000_0040;
        step();
        check("stbr_full_valid", {31'b0, s_valid}, 32'h1);
        br = 1'b0;
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        step();
        check("stbr_valid_cleared", {31'b0, s_valid}, 32'h0);
        check("stbr_inst_nop", s_inst, NOP);
        check("stbr_iaddr_zero", s_iaddr, 32'h0);
        check("stbr_target_addr", s_addr, 32'h40);
        check("stbr_req", {31'b0, s_req}, 32'h1);
        stall_b = 1'b0;
        drain(20, "stbr_drain");

        // PC wrap at the top of the address space, then reset mid-burst
        lat = 1;
        do_reset();
        br = 1'b1; br_addr = 32'hFFFF_FFFC;
        step();
        br = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        step();
        check("wrap_top_addr", s_addr, 32'hFFFF_FFFC);
        check("wrap_top_req", {31'b0, s_req}, 32'h1);
        step();
        check("wrap_next_addr", s_addr, 32'h0);
        step();
        check("wrap_deliver_top", s_iaddr, 32'hFFFF_FFFC);
        step();
        check("wrap_deliver_zero", s_iaddr, 32'h0);
        drain(0, "wrap_drain");
        rst_b = 1'b1;
        step();
        step();
        check_reset_outputs("midrst");
        rst_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
